uart_tx: RTL and testbench

Buffered UART transmitter: the send-side counterpart of the board's UART receiver. Accepts bytes over a valid/ready handshake into an internal FIFO and serialises each one as an 8N1 frame, LSB first, on `tx_uart`. Sits between user logic (e.g. a loopback or status reporter) and the board TX pin, sharing the receiver's baud parameterisation.

---
 rtl/uart_tx.sv | 175 +++++++++++++++++
 tb/tb_uart_tx.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: buffered 8N1 UART transmitter; a FIFO feeds an LSB-first serialiser on tx_uart.
// Define UART_TX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module uart_tx #(
  parameter int BPS        = 5208,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        tx_data,
  input  logic              tx_vld,
  output logic              tx_rdy,
  output logic              tx_uart,
  output logic              tx_busy,
  output logic [ADDR_W:0]   fifo_cnt
);

  localparam logic [15:0]       BAUD_LAST = 16'(BPS - 1);
  localparam logic [ADDR_W:0]   CNT_FULL  = (ADDR_W + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE   = (ADDR_W)'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  logic [7:0]        r_mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_cnt;
  state_t            r_state;
  logic [15:0]       r_baud;
  logic [2:0]        r_bit_cnt;
  logic [7:0]        r_shift;
  logic              r_tx;
`ifdef UART_TX_PARITY_EN
  logic              r_parity;
`endif

  state_t            w_next_state;
  logic              w_tx_next;
  logic              w_pop;
  logic              w_push;
  logic              w_shift_en;
  logic              w_bit_end;
  logic              w_empty;
  logic [7:0]        w_head;

  assign tx_rdy    = (r_cnt != CNT_FULL);
  assign w_push    = tx_vld && tx_rdy;
  assign w_empty   = (r_cnt == '0);
  assign w_head    = r_mem[r_rd_ptr];
  assign w_bit_end = (r_state != S_IDLE) && (r_baud == BAUD_LAST);
  assign tx_busy   = (r_state != S_IDLE);
  assign tx_uart   = r_tx;
  assign fifo_cnt  = r_cnt;

  // NOTE: storage carries no reset; only the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (w_push && !rst) r_mem[r_wr_ptr] <= tx_data;
  end

  // w_tx_next is the line level for the state being entered, so tx_uart comes straight from a flop.
  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_tx_next    = r_tx;
    w_pop        = 1'b0;
    w_shift_en   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_tx_next = 1'b1;
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_next_state = S_START;
          w_tx_next    = 1'b0;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_next_state = S_DATA;
          w_tx_next    = r_shift[0];
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          if (r_bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_next_state = S_PARITY;
            w_tx_next    = r_parity;
`else
            w_next_state = S_STOP;
            w_tx_next    = 1'b1;
`endif
          end else begin
            w_shift_en = 1'b1;
            w_tx_next  = r_shift[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_bit_end) begin
          w_next_state = S_STOP;
          w_tx_next    = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (w_bit_end) begin
          // Chain straight into the next start bit when more data is waiting.
          if (!w_empty) begin
            w_pop        = 1'b1;
            w_next_state = S_START;
            w_tx_next    = 1'b0;
          end else begin
            w_next_state = S_IDLE;
            w_tx_next    = 1'b1;
          end
        end
      end
      default: begin
        w_next_state = S_IDLE;
        w_tx_next    = 1'b1;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_tx      <= 1'b1;
      r_baud    <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_cnt     <= '0;
`ifdef UART_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      r_state <= w_next_state;
      r_tx    <= w_tx_next;

      if (r_state == S_IDLE || w_bit_end) r_baud <= '0;
      else                                r_baud <= r_baud + 16'd1;

      if (w_pop) begin
        r_shift   <= w_head;
        r_bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
        r_parity  <= ^w_head;
`endif
      end else if (w_shift_en) begin
        r_shift   <= {1'b0, r_shift[7:1]};
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end

      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;

      if (w_push && !w_pop)      r_cnt <= r_cnt + CNT_ONE;
      else if (w_pop && !w_push) r_cnt <= r_cnt - CNT_ONE;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized self-checking bench for uart_tx against a frame-level queue model.
// Build with UART_TX_PARITY_EN defined to exercise the parity variant.
`timescale 1ns/1ps
module tb_uart_tx;

  localparam int BPS   = 10;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
`ifdef UART_TX_PARITY_EN
  localparam int NB    = 11;
`else
  localparam int NB    = 10;
`endif
  localparam int FRAME = NB * BPS;

  logic          clk     = 1'b0;
  logic          rst     = 1'b1;
  logic [7:0]    tx_data = 8'h00;
  logic          tx_vld  = 1'b0;
  logic          tx_rdy;
  logic          tx_uart;
  logic          tx_busy;
  logic [AW:0]   fifo_cnt;

  uart_tx #(.BPS(BPS), .FIFO_DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_data  (tx_data),
    .tx_vld   (tx_vld),
    .tx_rdy   (tx_rdy),
    .tx_uart  (tx_uart),
    .tx_busy  (tx_busy),
    .fifo_cnt (fifo_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    int         start;
  } frame_t;

  int         cyc       = 0;
  int         n_checks  = 0;
  int         n_pass    = 0;
  int         n_rx      = 0;
  int         free_edge = 0;
  bit         track     = 1'b0;
  logic [7:0] mq[$];
  frame_t     exp_q[$];
  logic       par_q[$];

  // Frame-level model: bytes queue up, and the line takes one byte every FRAME cycles when free.
  always @(posedge clk) begin : ref_model
    bit         accept;
    bit         do_pop;
    logic [7:0] head;
    cyc = cyc + 1;
    if (rst) begin
      mq.delete();
      while (exp_q.size() > 0 && exp_q[$].start + FRAME >= cyc) void'(exp_q.pop_back());
      free_edge = 0;
    end else begin
      accept = tx_vld && (mq.size() < DEPTH);
      do_pop = (cyc >= free_edge) && (mq.size() > 0);
      if (do_pop) begin
        head = mq.pop_front();
        exp_q.push_back('{d: head, start: cyc});
        free_edge = cyc + FRAME;
      end
      if (accept) mq.push_back(tx_data);
    end
  end

  always @(negedge clk) begin
    if (track) begin
      n_checks++;
      if (fifo_cnt !== 4'(mq.size()) || tx_rdy !== (mq.size() != DEPTH) || tx_busy !== (cyc < free_edge))
        $display("FAIL cycle_state cyc=%0d got cnt=%0d rdy=%b busy=%b want cnt=%0d rdy=%b busy=%b",
                 cyc, fifo_cnt, tx_rdy, tx_busy, mq.size(), (mq.size() != DEPTH), (cyc < free_edge));
      else n_pass++;
    end
  end

  task automatic decode_frame();
    int             t0;
    logic [NB-1:0]  bits;
    bit             stable;
    bit             aborted;
    bit             par_bad;
    logic [7:0]     data;
    frame_t         e;
    t0      = cyc;
    bits    = '0;
    stable  = 1'b1;
    aborted = 1'b0;
    par_bad = 1'b0;
    for (int b = 0; b < NB; b++) begin
      for (int s = 0; s < BPS; s++) begin
        if (!aborted) begin
          if (b != 0 || s != 0) @(negedge clk);
          if (rst) aborted = 1'b1;
          else if (s == 0) bits[b] = tx_uart;
          else if (tx_uart !== bits[b]) stable = 1'b0;
        end
      end
    end
    if (!aborted) begin
      data = bits[8:1];
      n_rx++;
`ifdef UART_TX_PARITY_EN
      par_q.push_back(bits[9]);
`endif
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL frame_unexpected got data=%02h start=%0d want no frame", data, t0);
      end else begin
        e = exp_q.pop_front();
`ifdef UART_TX_PARITY_EN
        par_bad = (bits[9] !== ^e.d);
`endif
        if (!stable || bits[0] !== 1'b0 || bits[NB-1] !== 1'b1 || data !== e.d || t0 != e.start || par_bad)
          $display("FAIL frame got data=%02h start=%0d bits=%b stable=%0b want data=%02h start=%0d",
                   data, t0, bits, stable, e.d, e.start);
        else n_pass++;
      end
    end
  endtask

  initial begin : line_monitor
    forever begin
      @(negedge clk);
      if (!rst && tx_uart === 1'b0) decode_frame();
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [7:0] d);
    tx_data = d;
    tx_vld  = 1'b1;
    tick();
    tx_vld  = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || mq.size() != 0 || tx_busy !== 1'b0) && n < budget) begin
      tick();
      n++;
    end
    n_checks++;
    if (n >= budget) $display("FAIL wait_idle got timeout after %0d cycles want drained, pending=%0d", n, exp_q.size() + mq.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++; if (tx_uart !== 1'b1)  $display("FAIL reset_tx_uart got %b want 1", tx_uart); else n_pass++;
    n_checks++; if (tx_busy !== 1'b0)  $display("FAIL reset_tx_busy got %b want 0", tx_busy); else n_pass++;
    n_checks++; if (tx_rdy !== 1'b1)   $display("FAIL reset_tx_rdy got %b want 1", tx_rdy); else n_pass++;
    n_checks++; if (fifo_cnt !== 4'd0) $display("FAIL reset_fifo_cnt got %0d want 0", fifo_cnt); else n_pass++;
    rst   = 1'b0;
    track = 1'b1;
  endtask

  task automatic test_single();
    int busy_n;
    wait_idle(50);
    push(8'h55);
    n_checks++; if (fifo_cnt !== 4'd1) $display("FAIL single_cnt_after_push got %0d want 1", fifo_cnt); else n_pass++;
    n_checks++; if (tx_uart !== 1'b1)  $display("FAIL single_line_before_pop got %b want 1", tx_uart); else n_pass++;
    tick();
    n_checks++; if (tx_uart !== 1'b0)  $display("FAIL single_start_fall got %b want 0", tx_uart); else n_pass++;
    n_checks++; if (tx_busy !== 1'b1)  $display("FAIL single_busy_rise got %b want 1", tx_busy); else n_pass++;
    n_checks++; if (fifo_cnt !== 4'd0) $display("FAIL single_cnt_after_pop got %0d want 0", fifo_cnt); else n_pass++;
    busy_n = 1;
    while (tx_busy === 1'b1 && busy_n < 4 * FRAME) begin
      tick();
      if (tx_busy === 1'b1) busy_n++;
    end
    n_checks++; if (busy_n != FRAME)  $display("FAIL single_busy_len got %0d want %0d", busy_n, FRAME); else n_pass++;
    n_checks++; if (tx_uart !== 1'b1) $display("FAIL single_line_idle got %b want 1", tx_uart); else n_pass++;
  endtask

  task automatic test_burst();
    int peak    = 0;
    bit rdy_low = 1'b0;
    int t_first = 0;
    int rx0;
    int guard   = 0;
    wait_idle(50);
    rx0 = n_rx;
    for (int i = 0; i < 8; i++) begin
      tx_data = 8'(i);
      tx_vld  = 1'b1;
      tick();
      if (i == 0) t_first = cyc + 1;
      if (int'(fifo_cnt) > peak) peak = int'(fifo_cnt);
      if (tx_rdy !== 1'b1) rdy_low = 1'b1;
    end
    tx_vld = 1'b0;
    n_checks++; if (peak != 7)          $display("FAIL burst_peak_cnt got %0d want 7", peak); else n_pass++;
    n_checks++; if (rdy_low !== 1'b0)   $display("FAIL burst_rdy_dropped got %b want 0", rdy_low); else n_pass++;
    while (tx_busy === 1'b1 && guard < 16 * FRAME) begin
      tick();
      guard++;
    end
    n_checks++;
    if (cyc - t_first != 8 * FRAME) $display("FAIL burst_total_len got %0d want %0d", cyc - t_first, 8 * FRAME);
    else n_pass++;
    wait_idle(2 * FRAME);
    n_checks++; if (n_rx - rx0 != 8) $display("FAIL burst_frames got %0d want 8", n_rx - rx0); else n_pass++;
  endtask

  task automatic test_overflow();
    bit drop_seen = 1'b0;
    int cnt_drop  = -1;
    int rx0;
    wait_idle(50);
    rx0 = n_rx;
    for (int i = 0; i < 10; i++) begin
      tx_data = 8'hA0 + 8'(i);
      tx_vld  = 1'b1;
      tick();
      if (!drop_seen && tx_rdy === 1'b0) begin
        drop_seen = 1'b1;
        cnt_drop  = int'(fifo_cnt);
      end
    end
    tx_vld = 1'b0;
    n_checks++; if (drop_seen !== 1'b1) $display("FAIL overflow_rdy_drop got %b want 1", drop_seen); else n_pass++;
    n_checks++; if (cnt_drop != DEPTH)  $display("FAIL overflow_cnt_at_drop got %0d want %0d", cnt_drop, DEPTH); else n_pass++;
    wait_idle(12 * FRAME);
    n_checks++; if (n_rx - rx0 != 9) $display("FAIL overflow_frames got %0d want 9", n_rx - rx0); else n_pass++;
  endtask

  task automatic test_simultaneous();
    int         n0;
    int         target;
    int         rx0;
    logic [7:0] x;
    logic [7:0] y;
    wait_idle(50);
    rx0 = n_rx;
    x = 8'($urandom);
    y = 8'($urandom);
    push(x);
    n0 = cyc;
    tick();
    tick();
    push(y);
    target = n0 + 1 + FRAME;
    while (cyc < target - 1) tick();
    push(8'h3C);
    n_checks++; if (cyc != target)     $display("FAIL simul_edge got %0d want %0d", cyc, target); else n_pass++;
    n_checks++; if (fifo_cnt !== 4'd1) $display("FAIL simul_cnt got %0d want 1", fifo_cnt); else n_pass++;
    n_checks++; if (tx_uart !== 1'b0)  $display("FAIL simul_no_gap got %b want 0", tx_uart); else n_pass++;
    wait_idle(4 * FRAME);
    n_checks++; if (n_rx - rx0 != 3) $display("FAIL simul_frames got %0d want 3", n_rx - rx0); else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    int n0;
    int rst_edge;
    int rx0;
    wait_idle(50);
    rx0 = n_rx;
    push(8'($urandom));
    n0 = cyc;
    push(8'($urandom));
    push(8'($urandom));
    rst_edge = n0 + 1 + 4 * BPS + BPS / 2;
    while (cyc < rst_edge - 1) tick();
    rst     = 1'b1;
    tx_data = 8'hEE;
    tx_vld  = 1'b1;
    tick();
    rst    = 1'b0;
    tx_vld = 1'b0;
    n_checks++; if (tx_uart !== 1'b1)  $display("FAIL midrst_tx_uart got %b want 1", tx_uart); else n_pass++;
    n_checks++; if (tx_busy !== 1'b0)  $display("FAIL midrst_tx_busy got %b want 0", tx_busy); else n_pass++;
    n_checks++; if (fifo_cnt !== 4'd0) $display("FAIL midrst_fifo_cnt got %0d want 0", fifo_cnt); else n_pass++;
    n_checks++; if (tx_rdy !== 1'b1)   $display("FAIL midrst_tx_rdy got %b want 1", tx_rdy); else n_pass++;
    push(8'hF0);
    wait_idle(3 * FRAME);
    n_checks++; if (n_rx - rx0 != 1) $display("FAIL midrst_frames got %0d want 1", n_rx - rx0); else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 25)) tick();
      for (int k = 0; k < int'($urandom_range(1, 4)); k++) begin
        tx_data = 8'($urandom);
        tx_vld  = 1'b1;
        tick();
      end
      tx_vld = 1'b0;
    end
    wait_idle(140 * FRAME);
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    logic p0;
    logic p1;
    wait_idle(50);
    par_q.delete();
    push(8'h07);
    push(8'h03);
    wait_idle(4 * FRAME);
    n_checks++;
    if (par_q.size() != 2) begin
      $display("FAIL parity_frames got %0d want 2", par_q.size());
    end else begin
      n_pass++;
      p0 = par_q[0];
      p1 = par_q[1];
      n_checks++; if (p0 !== 1'b1) $display("FAIL parity_07 got %b want 1", p0); else n_pass++;
      n_checks++; if (p1 !== 1'b0) $display("FAIL parity_03 got %b want 0", p1); else n_pass++;
    end
  endtask
`endif

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

  initial begin : main
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_simultaneous();
    test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_random();
    track = 1'b0;
    n_checks++;
    if (exp_q.size() != 0 || mq.size() != 0) $display("FAIL final_drain got pending=%0d want 0", exp_q.size() + mq.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
